// File: rtl/serial_tx_core.sv
// Transmit back end of the serial IP: byte FIFO fed by the register block,
// drained by a UART-style serialiser (start, 8 data LSB first, optional parity, 1/2 stop).
module serial_tx_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_WIDTH = 16
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset,
    input  logic                          enable,
    input  logic [BAUD_WIDTH-1:0]         baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    input  logic                          overflow_clear,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          overflow,
    output logic                          tx_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic                  ovf_q, ovf_d;

    // Per-frame latched configuration and shift datapath
    logic [BAUD_WIDTH-1:0] baud_eff;
    logic [BAUD_WIDTH-1:0] baud_q, baud_d;
    logic [BAUD_WIDTH-1:0] cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  par_bit_q, par_bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_idx_q, bit_idx_d;

    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  can_start;
    logic                  bit_end;
    logic                  frame_end;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    // Frame control decodes shared by the FSM and the datapath
    always_comb begin
        can_start = enable && !empty_q;
        bit_end   = (state_q != S_IDLE) && (cnt_q == '0);
        frame_end = (state_q == S_STOP) && bit_end && (!two_stop_q || bit_idx_q[0]);
        pop       = ((state_q == S_IDLE) || frame_end) && can_start;
        push_ok   = wr_valid && (!full_q || pop);
        drop      = wr_valid && !push_ok;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (frame_end) begin
                    state_d = can_start ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state that produces them
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE);
        done_d = frame_end;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        baud_eff   = (baud_div < BAUD_WIDTH'(2)) ? BAUD_WIDTH'(2) : baud_div;
        baud_d     = baud_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        par_bit_d  = par_bit_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        if (pop) begin
            baud_d     = baud_eff;
            cnt_d      = baud_eff - BAUD_WIDTH'(1);
            par_en_d   = parity_en;
            two_stop_d = two_stop;
            shift_d    = mem_q[rd_ptr_q];
            par_bit_d  = (^mem_q[rd_ptr_q]) ^ parity_odd;
            bit_idx_d  = '0;
        end else if (bit_end) begin
            cnt_d = baud_q - BAUD_WIDTH'(1);
            if (state_q == S_DATA) begin
                // bit_idx wraps 7 -> 0 so STOP/PARITY start from index 0
                shift_d   = {1'b0, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end else if (state_q == S_STOP) begin
                bit_idx_d = bit_idx_q + 3'd1;
            end else begin
                bit_idx_d = '0;
            end
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q - BAUD_WIDTH'(1);
        end
    end

    always_comb begin
        wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            baud_q     <= BAUD_WIDTH'(2);
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            ovf_q      <= ovf_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            par_bit_q  <= par_bit_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign overflow   = ovf_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_serial_tx_core.sv
// Bench for serial_tx_core: a per-cycle waveform-queue model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized traffic.
module tb_serial_tx_core;

    localparam int DEPTH = 16;
    localparam int BW    = 16;

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic          enable = 1'b0;
    logic [BW-1:0] baud_div = BW'(4);
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          two_stop = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_valid = 1'b0;
    logic          overflow_clear = 1'b0;
    logic          tx, busy, fifo_full, fifo_empty, overflow, tx_done;
    logic [4:0]    fifo_count;

    int vectors = 0;
    int miscompares = 0;

    serial_tx_core #(.FIFO_DEPTH(DEPTH), .BAUD_WIDTH(BW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .enable(enable),
        .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .wr_data(wr_data), .wr_valid(wr_valid),
        .overflow_clear(overflow_clear), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .tx_done(tx_done)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge axi_clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // Model: queued bytes, plus the remaining per-cycle line levels of the current frame
    logic [7:0] m_fifo[$];
    logic       m_wave[$];
    logic       m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    bit         model_on = 1'b0;

    always @(posedge axi_clk) begin : model
        int         sz;
        int         bd;
        bit         pop_now;
        bit         drop;
        logic [7:0] b;
        if (axi_reset) begin
            m_fifo.delete();
            m_wave.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
            model_on = 1'b1;
        end else begin
            sz      = m_wave.size();
            m_tx    = (sz > 0) ? m_wave[0] : 1'b1;
            m_busy  = (sz > 0);
            m_done  = (sz == 1);
            pop_now = (sz <= 1) && enable && (m_fifo.size() > 0);
            if (sz > 0) m_wave.delete(0);
            if (pop_now) begin
                b  = m_fifo.pop_front();
                bd = (baud_div < 2) ? 2 : int'(baud_div);
                repeat (bd) m_wave.push_back(1'b0);
                for (int k = 0; k < 8; k++) repeat (bd) m_wave.push_back(b[k]);
                if (parity_en) repeat (bd) m_wave.push_back((^b) ^ parity_odd);
                repeat (two_stop ? 2 * bd : bd) m_wave.push_back(1'b1);
            end
            drop = 1'b0;
            if (wr_valid) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(wr_data);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (overflow_clear) m_ovf = 1'b0;
        end
    end

    always @(negedge axi_clk) begin
        if (model_on) begin
            check("tx", tx, m_tx);
            check("busy", busy, m_busy);
            check("tx_done", tx_done, m_done);
            check("fifo_count", fifo_count, m_fifo.size());
            check("fifo_full", fifo_full, m_fifo.size() == DEPTH);
            check("fifo_empty", fifo_empty, m_fifo.size() == 0);
            check("overflow", overflow, m_ovf);
        end
    end

    // Waits for the start bit, then records the line until busy drops
    task automatic capture(output logic [63:0] txv, output int blen, output int didx, output int dcnt);
        int n;
        txv = '0; didx = -1; dcnt = 0; n = 0; blen = 0;
        while (tx !== 1'b0 && n < 40) begin tick(); n++; end
        check("capture_start", tx === 1'b0, 1);
        while (busy === 1'b1 && blen < 2000) begin
            if (blen < 64) txv[blen] = tx;
            if (tx_done === 1'b1) begin didx = blen; dcnt++; end
            blen++;
            tick();
        end
        check("capture_end", busy === 1'b0, 1);
    endtask

    initial begin
        logic [63:0] txv;
        int blen, didx, dcnt, n;

        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", tx_done, 0);
        axi_reset = 1'b0;
        tick();

        // 8N1 at 4 clocks/bit, 0xA5
        baud_div = BW'(4); enable = 1'b1;
        push(8'hA5);
        n = 0;
        while (tx !== 1'b0 && n < 10) begin tick(); n++; end
        check("t1_latency", n, 2);
        capture(txv, blen, didx, dcnt);
        check("t1_wave", txv[39:0], 40'b1111_1111_0000_1111_0000_0000_1111_0000_1111_0000);
        check("t1_done_idx", didx, 39);
        check("t1_busy_len", blen, 40);
        check("t1_done_cnt", dcnt, 1);

        // parity on 0x07 (three ones)
        enable = 1'b0; baud_div = BW'(2); parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
        push(8'h07);
        enable = 1'b1;
        capture(txv, blen, didx, dcnt);
        check("t2_parity_even", txv[18], 1);
        check("t2_len_2stop", blen, 24);
        enable = 1'b0; parity_odd = 1'b1; two_stop = 1'b0;
        push(8'h07);
        enable = 1'b1;
        capture(txv, blen, didx, dcnt);
        check("t2_parity_odd", txv[18], 0);
        check("t2_len_1stop", blen, 22);

        // overfill with enable low, then drain
        enable = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(i));
        check("t3_count", fifo_count, 16);
        check("t3_full", fifo_full, 1);
        check("t3_ovf", overflow, 1);
        enable = 1'b1;
        capture(txv, blen, didx, dcnt);
        check("t3_frames", dcnt, 16);
        check("t3_busy_len", blen, 320);
        check("t3_drained", fifo_count, 0);
        check("t3_ovf_sticky", overflow, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // back-to-back frames
        enable = 1'b0; baud_div = BW'(3);
        repeat (3) push(8'($urandom));
        enable = 1'b1;
        capture(txv, blen, didx, dcnt);
        check("t4_busy_len", blen, 90);
        check("t4_frames", dcnt, 3);

        // enable dropped mid-frame
        enable = 1'b0; baud_div = BW'(4);
        push(8'h3C); push(8'hC3);
        enable = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin tick(); n++; end
        repeat (8) tick();
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        check("t5_frame_done", busy === 1'b0, 1);
        repeat (3) tick();
        check("t5_idle", busy, 0);
        check("t5_count", fifo_count, 1);
        enable = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 5) begin tick(); n++; end
        check("t5_restart", n, 2);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end

        // reset mid-frame with a full queue and overflow set
        enable = 1'b0;
        for (int i = 0; i < 17; i++) push(8'($urandom));
        enable = 1'b1;
        repeat (12) tick();
        axi_reset = 1'b1;
        tick();
        check("t6_tx", tx, 1);
        check("t6_busy", busy, 0);
        check("t6_count", fifo_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_done", tx_done, 0);
        axi_reset = 1'b0;
        dcnt = 0;
        repeat (20) begin tick(); if (tx_done === 1'b1) dcnt++; end
        check("t6_no_done", dcnt, 0);

        // randomized traffic
        enable = 1'b1;
        repeat (4000) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) baud_div = BW'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) parity_en = ~parity_en;
            if ($urandom_range(0, 99) == 0) parity_odd = ~parity_odd;
            if ($urandom_range(0, 99) == 0) two_stop = ~two_stop;
            overflow_clear = ($urandom_range(0, 29) == 0);
            axi_reset = ($urandom_range(0, 1499) == 0);
            tick();
        end
        wr_valid = 1'b0; overflow_clear = 1'b0; axi_reset = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
